// File: rtl/ov7670_pkg.sv
// ov7670_pkg: frame-timing state encoding, pattern_sel codes and the
// RGB565 colour-bar palette shared by the OV7670 stream emulator.
package ov7670_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_VSYNC  = 3'd1,
      ST_VBACK  = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_VFRONT = 3'd4
   } state_t;

   localparam logic [1:0] PAT_BARS      = 2'd0;
   localparam logic [1:0] PAT_COORD     = 2'd1;
   localparam logic [1:0] PAT_CHECKER   = 2'd2;
   localparam logic [1:0] PAT_SOLID_RED = 2'd3;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   // Bar colour by bar index, left to right across the line.
   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_colour = BAR_WHITE;
         3'd1:    bar_colour = BAR_YELLOW;
         3'd2:    bar_colour = BAR_CYAN;
         3'd3:    bar_colour = BAR_GREEN;
         3'd4:    bar_colour = BAR_MAGENTA;
         3'd5:    bar_colour = BAR_RED;
         3'd6:    bar_colour = BAR_BLUE;
         default: bar_colour = BAR_BLACK;
      endcase
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ov7670_pattern_gen.sv
// ov7670_pattern_gen: combinational RGB565 test-pattern lookup from pixel
// coordinates, the latched pattern code and the frame parity.
module ov7670_pattern_gen
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE = 320,
   parameter int XW       = 9,
   parameter int YW       = 8
)
(
   input  logic [XW-1:0] i_x,
   input  logic [YW-1:0] i_y,
   input  logic [1:0]    i_pattern,
   input  logic          i_frame_lsb,
   output logic [15:0]   o_pixel
);

   // Width of one colour bar; H_ACTIVE is a multiple of 8 so this is exact.
   localparam int BAR_W = H_ACTIVE / 8;

   logic [7:1] w_ge;
   logic [2:0] w_bar;
   logic [7:0] w_x8;
   logic [7:0] w_y8;

   assign w_x8 = 8'(i_x);
   assign w_y8 = 8'(i_y);

   // One comparator per bar boundary; the bar index is how many are passed.
   for (genvar gi = 1; gi < 8; gi++) begin : g_bar_edge
      assign w_ge[gi] = (int'(i_x) >= gi * BAR_W);
   end

   // Count passed bar boundaries to get the bar index.
   always_comb begin
      w_bar = 3'd0;
      for (int i = 1; i < 8; i++) begin
         w_bar = w_bar + {2'b00, w_ge[i]};
      end
   end

   // Select the pixel colour for the requested pattern.
   always_comb begin
      o_pixel = BAR_RED;
      case (i_pattern)
         PAT_BARS:    o_pixel = bar_colour(w_bar);
         PAT_COORD:   o_pixel = {w_y8, w_x8};
         PAT_CHECKER: o_pixel = (w_x8[2] ^ w_y8[2] ^ i_frame_lsb) ? 16'hFFFF : 16'h0000;
         default:     o_pixel = BAR_RED;
      endcase
   end

endmodule

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen: OV7670 camera emulator driving vsync/href/d with RGB565
// test patterns, one byte per clock, high byte first.
// Optional per-frame byte checksum: define OV7670_STREAM_GEN_CHECKSUM_EN.
module ov7670_stream_gen
   import ov7670_pkg::*;
#(
   parameter int H_ACTIVE    = 320,
   parameter int V_ACTIVE    = 240,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  d,
   output logic        frame_done,
   output logic [7:0]  frame_count,
   output logic [15:0] frame_checksum
);

   localparam int LP   = 2 * H_ACTIVE + H_BLANK;
   localparam int HW   = $clog2(LP);
   localparam int VMAX = max2(max2(VSYNC_LINES, V_BACK), max2(V_ACTIVE, V_FRONT));
   localparam int VW   = $clog2(VMAX + 1);
   localparam int XW   = $clog2(H_ACTIVE);

   localparam logic [HW-1:0] HC_LAST  = HW'(LP - 1);
   localparam logic [HW-1:0] HREF_END = HW'(2 * H_ACTIVE);
   localparam logic [VW-1:0] VS_LAST  = VW'(VSYNC_LINES - 1);
   localparam logic [VW-1:0] VB_LAST  = VW'(V_BACK - 1);
   localparam logic [VW-1:0] VA_LAST  = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VF_LAST  = VW'(V_FRONT - 1);

   state_t        r_state, w_state_next;
   logic [HW-1:0] r_hc, w_hc_next;
   logic [VW-1:0] r_vc, w_vc_next;
   logic [1:0]    r_pattern, w_pattern_next;
   logic          w_frame_start;
   logic          w_line_end;
   logic          w_vc_last;

   logic          r_vsync, r_href, r_frame_done;
   logic [7:0]    r_d, r_frame_count;
   logic          w_vsync_next, w_href_next, w_done_next;
   logic [7:0]    w_d_next;
   logic [15:0]   w_pixel;
   logic [XW-1:0] w_x;

   // Next-state and counter logic; outputs are derived from these next values
   // so they land in registers on the same edge as the state.
   always_comb begin
      w_state_next   = r_state;
      w_hc_next      = r_hc;
      w_vc_next      = r_vc;
      w_pattern_next = r_pattern;
      w_frame_start  = 1'b0;
      w_line_end     = (r_hc == HC_LAST);
      case (r_state)
         ST_VSYNC:  w_vc_last = (r_vc == VS_LAST);
         ST_VBACK:  w_vc_last = (r_vc == VB_LAST);
         ST_ACTIVE: w_vc_last = (r_vc == VA_LAST);
         ST_VFRONT: w_vc_last = (r_vc == VF_LAST);
         default:   w_vc_last = 1'b0;
      endcase
      case (r_state)
         ST_IDLE: begin
            if (enable) w_frame_start = 1'b1;
         end
         default: begin
            w_hc_next = w_line_end ? '0 : r_hc + 1'b1;
            if (w_line_end) begin
               if (w_vc_last) begin
                  w_vc_next = '0;
                  case (r_state)
                     ST_VSYNC:  w_state_next = ST_VBACK;
                     ST_VBACK:  w_state_next = ST_ACTIVE;
                     ST_ACTIVE: w_state_next = ST_VFRONT;
                     default: begin
                        // End of frame: back-to-back frames skip IDLE entirely.
                        if (enable) w_frame_start = 1'b1;
                        else        w_state_next  = ST_IDLE;
                     end
                  endcase
               end else begin
                  w_vc_next = r_vc + 1'b1;
               end
            end
         end
      endcase
      if (w_frame_start) begin
         w_state_next   = ST_VSYNC;
         w_hc_next      = '0;
         w_vc_next      = '0;
         w_pattern_next = pattern_sel;
      end
   end

   // Pixel x is the byte position halved; only meaningful while href is high.
   assign w_x = w_hc_next[XW:1];

   ov7670_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .XW       (XW),
      .YW       (VW)
   ) u_pattern (
      .i_x         (w_x),
      .i_y         (w_vc_next),
      .i_pattern   (w_pattern_next),
      .i_frame_lsb (r_frame_count[0]),
      .o_pixel     (w_pixel)
   );

   // Bus values for the upcoming cycle; d is forced low outside href.
   always_comb begin
      w_vsync_next = (w_state_next == ST_VSYNC);
      w_href_next  = (w_state_next == ST_ACTIVE) && (w_hc_next < HREF_END);
      w_d_next     = 8'h00;
      if (w_href_next) w_d_next = w_hc_next[0] ? w_pixel[7:0] : w_pixel[15:8];
      w_done_next  = (w_state_next == ST_VFRONT) && (w_hc_next == HC_LAST) &&
                     (w_vc_next == VF_LAST);
   end

   // State, counters and registered bus outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_hc          <= '0;
         r_vc          <= '0;
         r_pattern     <= PAT_BARS;
         r_vsync       <= 1'b0;
         r_href        <= 1'b0;
         r_d           <= 8'h00;
         r_frame_done  <= 1'b0;
         r_frame_count <= 8'h00;
      end else begin
         r_state      <= w_state_next;
         r_hc         <= w_hc_next;
         r_vc         <= w_vc_next;
         r_pattern    <= w_pattern_next;
         r_vsync      <= w_vsync_next;
         r_href       <= w_href_next;
         r_d          <= w_d_next;
         r_frame_done <= w_done_next;
         if (w_done_next) r_frame_count <= r_frame_count + 8'd1;
      end
   end

   assign vsync       = r_vsync;
   assign href        = r_href;
   assign d           = r_d;
   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;

`ifdef OV7670_STREAM_GEN_CHECKSUM_EN
   logic [15:0] r_csum_acc;
   logic [15:0] r_checksum;

   // Running sum of every href byte, published on the frame_done edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_csum_acc <= 16'h0000;
         r_checksum <= 16'h0000;
      end else begin
         if (w_frame_start)    r_csum_acc <= 16'h0000;
         else if (w_href_next) r_csum_acc <= r_csum_acc + {8'h00, w_d_next};
         if (w_done_next)      r_checksum <= r_csum_acc;
      end
   end

   assign frame_checksum = r_checksum;
`else
   assign frame_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb_ov7670_stream_gen: directed + randomized bench for ov7670_stream_gen,
// checked every cycle against a frame-offset reference model.
module tb_ov7670_stream_gen;

   localparam int HA    = 8;
   localparam int VA    = 4;
   localparam int HB    = 4;
   localparam int VSL   = 1;
   localparam int VBK   = 1;
   localparam int VFR   = 1;
   localparam int LP    = 2 * HA + HB;
   localparam int FRAME = (VSL + VBK + VA + VFR) * LP;

   localparam logic [15:0] BAR_COLS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
   localparam logic [7:0]  BAR_LINE0 [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF,
                                              8'h07, 8'hE0, 8'hF8, 8'h1F, 8'hF8, 8'h00,
                                              8'h00, 8'h1F, 8'h00, 8'h00};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic        vsync, href, frame_done;
   logic [7:0]  d, frame_count;
   logic [15:0] frame_checksum;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: a frame is just a cycle offset m_t in 0..FRAME-1.
   bit m_active = 1'b0;
   int m_t = 0;
   int m_pat = 0;
   int m_count = 0;
   int m_acc = 0;
   int m_ck = 0;

   bit         cap_en = 1'b0;
   logic [7:0] cap_q [$];

   ov7670_stream_gen #(
      .H_ACTIVE    (HA),
      .V_ACTIVE    (VA),
      .H_BLANK     (HB),
      .VSYNC_LINES (VSL),
      .V_BACK      (VBK),
      .V_FRONT     (VFR)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .enable         (enable),
      .pattern_sel    (pattern_sel),
      .vsync          (vsync),
      .href           (href),
      .d              (d),
      .frame_done     (frame_done),
      .frame_count    (frame_count),
      .frame_checksum (frame_checksum)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ref_pixel(int pat, int x, int y, int fc);
      case (pat)
         0:       return BAR_COLS[x * 8 / HA];
         1:       return 16'(((y % 256) * 256) + (x % 256));
         2:       return ((((x >> 2) ^ (y >> 2) ^ fc) & 1) != 0) ? 16'hFFFF : 16'h0000;
         default: return 16'hF800;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs the DUT just sampled.
   task automatic model_update();
      if (!reset_n) begin
         m_active = 1'b0; m_t = 0; m_count = 0; m_acc = 0; m_ck = 0;
      end else if (!m_active) begin
         if (enable) begin
            m_active = 1'b1; m_t = 0; m_pat = int'(pattern_sel); m_acc = 0;
         end
      end else if (m_t == FRAME - 1) begin
         if (enable) begin
            m_t = 0; m_pat = int'(pattern_sel); m_acc = 0;
         end else begin
            m_active = 1'b0;
         end
      end else begin
         m_t++;
         if (m_t == FRAME - 1) begin
            m_count = (m_count + 1) % 256;
            m_ck    = m_acc;
            $display("frame %0d done: pattern %0d bytesum %04h", m_count, m_pat, m_acc);
         end
      end
   endtask

   task automatic check_outputs();
      logic        ev, eh, efd;
      logic [7:0]  ed;
      logic [15:0] px;
      int          line, hcm;
      ev = 1'b0; eh = 1'b0; efd = 1'b0; ed = 8'h00;
      if (m_active) begin
         line = m_t / LP;
         hcm  = m_t % LP;
         ev   = (line < VSL);
         eh   = (line >= VSL + VBK) && (line < VSL + VBK + VA) && (hcm < 2 * HA);
         if (eh) begin
            px = ref_pixel(m_pat, hcm / 2, line - VSL - VBK, m_count % 2);
            ed = ((hcm % 2) == 0) ? px[15:8] : px[7:0];
            m_acc = (m_acc + int'(ed)) % 65536;
         end
         efd = (m_t == FRAME - 1);
      end
      chk("vsync", {15'd0, vsync}, {15'd0, ev});
      chk("href", {15'd0, href}, {15'd0, eh});
      chk("d", {8'd0, d}, {8'd0, ed});
      chk("frame_done", {15'd0, frame_done}, {15'd0, efd});
      chk("frame_count", {8'd0, frame_count}, 16'(m_count));
`ifdef OV7670_STREAM_GEN_CHECKSUM_EN
      chk("frame_checksum", frame_checksum, 16'(m_ck));
`else
      chk("frame_checksum", frame_checksum, 16'h0000);
`endif
      if (cap_en && href) cap_q.push_back(d);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      check_outputs();
   endtask

   task automatic run_until(input int target);
      int budget;
      budget = 4 * FRAME;
      while (!(m_active && m_t == target) && budget > 0) begin
         tick();
         budget--;
      end
      chk("reach_target", {15'd0, (m_active && m_t == target)}, 16'h0001);
   endtask

   initial begin
      // Reset held with enable high: everything stays low.
      reset_n = 1'b0; enable = 1'b1; pattern_sel = 2'd0;
      repeat (3) tick();
      chk("reset_vsync", {15'd0, vsync}, 16'h0000);

      // Release: vsync rises on the first edge that sees enable out of reset.
      reset_n = 1'b1; cap_en = 1'b1;
      tick();
      chk("vsync_latency", {15'd0, vsync}, 16'h0001);

      // Three colour-bar frames back to back.
      run_until(FRAME - 1);
      chk("count_after_1", {8'd0, frame_count}, 16'h0001);
      cap_en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("bar_line0", (i < cap_q.size()) ? {8'd0, cap_q[i]} : 16'hDEAD, {8'd0, BAR_LINE0[i]});
      end
      tick();
      run_until(FRAME - 1);
      tick();
      run_until(FRAME - 1);
      chk("count_after_3", {8'd0, frame_count}, 16'h0003);

      // Coordinate pattern latched at VSYNC entry, then a mid-frame change to red.
      pattern_sel = 2'd1;
      tick();
      run_until(30);
      pattern_sel = 2'd3;
      run_until((VSL + VBK + 2) * LP + 10);
      chk("coord_hi", {8'd0, d}, 16'h0002);
      tick();
      chk("coord_lo", {8'd0, d}, 16'h0005);
      run_until(FRAME - 1);
      tick();
      run_until((VSL + VBK) * LP);
      chk("red_hi", {8'd0, d}, 16'h00F8);
      tick();
      chk("red_lo", {8'd0, d}, 16'h0000);
      run_until(FRAME - 1);
`ifdef OV7670_STREAM_GEN_CHECKSUM_EN
      chk("checksum_red", frame_checksum, 16'h1F00);
`else
      chk("checksum_off", frame_checksum, 16'h0000);
`endif

      // Enable dropped at cycle 50: frame completes, then IDLE.
      pattern_sel = 2'd2;
      tick();
      run_until(50);
      enable = 1'b0;
      run_until(FRAME - 1);
      chk("stop_done", {15'd0, frame_done}, 16'h0001);
      repeat (5) tick();
      chk("idle_vsync", {15'd0, vsync}, 16'h0000);

      // Restart, then re-assert enable exactly on the frame_done cycle.
      enable = 1'b1;
      tick();
      run_until(50);
      enable = 1'b0;
      run_until(FRAME - 1);
      enable = 1'b1;
      tick();
      chk("reenter_vsync", {15'd0, vsync}, 16'h0001);

      // Reset mid-frame at cycle 70: outputs clear, count clears, no frame_done.
      run_until(70);
      reset_n = 1'b0;
      tick();
      chk("midreset_count", {8'd0, frame_count}, 16'h0000);
      chk("midreset_done", {15'd0, frame_done}, 16'h0000);
      reset_n = 1'b1;

      // Randomized traffic: pattern changes, enable toggles, occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 29) == 0) pattern_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 249) == 0) enable = ~enable;
         reset_n = ($urandom_range(0, 999) != 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
